// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared FU completion types and ROB tag age compare
package riscv_pkg;

  localparam int ReorderBufferTagWidth = 4;

  typedef logic [ReorderBufferTagWidth-1:0] rob_tag_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

  typedef enum logic [4:0] {
    EXC_INSTR_MISALIGNED = 5'd0,
    EXC_INSTR_FAULT      = 5'd1,
    EXC_ILLEGAL_INSTR    = 5'd2,
    EXC_BREAKPOINT       = 5'd3,
    EXC_LOAD_MISALIGNED  = 5'd4,
    EXC_LOAD_FAULT       = 5'd5,
    EXC_STORE_MISALIGNED = 5'd6,
    EXC_STORE_FAULT      = 5'd7
  } exc_cause_t;

  typedef struct packed {
    logic       valid;
    rob_tag_t   tag;
    logic [63:0] value;
    logic       exception;
    exc_cause_t exc_cause;
    fp_flags_t  fp_flags;
  } fu_complete_t;

  // Age relative to the ROB head, computed one bit wider than the tag so the
  // distance never aliases; an entry equal to flush_tag is not younger.
  function automatic logic tag_is_younger(input rob_tag_t tag,
                                          input rob_tag_t flush_tag,
                                          input rob_tag_t head_tag);
    logic [ReorderBufferTagWidth:0] age_entry;
    logic [ReorderBufferTagWidth:0] age_flush;
    age_entry = {1'b0, tag} - {1'b0, head_tag};
    age_flush = {1'b0, flush_tag} - {1'b0, head_tag};
    return age_entry > age_flush;
  endfunction

endpackage

// File: rtl/fu_cdb_adapter.sv
// rtl/fu_cdb_adapter.sv - FU completion buffer feeding one CDB arbiter slot
module fu_cdb_adapter
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  fu_complete_t i_fu_complete,
  output fu_complete_t o_cdb_req,
  input  logic         i_cdb_grant,
  output logic         o_fu_stall,
  output logic         o_overflow,
  input  logic         i_flush,
  input  logic         i_flush_en,
  input  rob_tag_t     i_flush_tag,
  input  rob_tag_t     i_rob_head_tag
);

  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam ptr_t LastPtr  = ptr_t'(DEPTH - 1);
  localparam cnt_t FullCnt  = cnt_t'(DEPTH);
  localparam cnt_t StallCnt = cnt_t'(DEPTH - 1);

  fu_complete_t     entry_q [DEPTH];
  fu_complete_t     entry_d [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [DEPTH-1:0] killed_q, killed_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  ptr_t             wr_ptr_q, wr_ptr_d;
  cnt_t             count_q, count_d;
  logic             overflow_q, overflow_d;

  logic head_live;
  logic head_killed;
  logic req_valid;
  logic full;
  logic in_younger;
  logic in_ok;
  logic push;
  logic pop;

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  // Head status and push/pop decisions; flush overrides grant and input.
  always_comb begin
    head_live   = live_q[rd_ptr_q];
    head_killed = killed_q[rd_ptr_q];
    req_valid   = head_live & ~head_killed;
    full        = (count_q == FullCnt);
    in_younger  = i_flush_en &
                  tag_is_younger(i_fu_complete.tag, i_flush_tag, i_rob_head_tag);
    in_ok       = i_fu_complete.valid & ~i_flush & ~in_younger;
    pop         = ~i_flush & head_live & (head_killed | i_cdb_grant);
    push        = in_ok & (~full | pop);
  end

  // Next-state: kill marking, then pop, then push so a full push+pop can
  // reuse the slot being vacated.
  always_comb begin
    entry_d    = entry_q;
    live_d     = live_q;
    killed_d   = killed_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (in_ok & full & ~pop);

    if (i_flush) begin
      live_d   = '0;
      killed_d = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (i_flush_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (live_q[i] &&
              tag_is_younger(entry_q[i].tag, i_flush_tag, i_rob_head_tag)) begin
            killed_d[i] = 1'b1;
          end
        end
      end
      if (pop) begin
        live_d[rd_ptr_q]   = 1'b0;
        killed_d[rd_ptr_q] = 1'b0;
        rd_ptr_d           = ptr_inc(rd_ptr_q);
      end
      if (push) begin
        entry_d[wr_ptr_q]  = i_fu_complete;
        live_d[wr_ptr_q]   = 1'b1;
        killed_d[wr_ptr_q] = 1'b0;
        wr_ptr_d           = ptr_inc(wr_ptr_q);
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // Control state; reset wins over everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      live_q     <= '0;
      killed_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      live_q     <= live_d;
      killed_q   <= killed_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset; it is only visible behind a live bit.
  always_ff @(posedge i_clk) begin
    entry_q <= entry_d;
  end

  // Registered-only outputs; payload reads zero whenever no request is made.
  always_comb begin
    o_cdb_req = '0;
    if (req_valid) begin
      o_cdb_req       = entry_q[rd_ptr_q];
      o_cdb_req.valid = 1'b1;
    end
    o_fu_stall = (count_q >= StallCnt);
    o_overflow = overflow_q;
  end

endmodule

// File: tb/tb_fu_cdb_adapter.sv
// tb/tb_fu_cdb_adapter.sv - directed table and randomized model bench for fu_cdb_adapter
module tb_fu_cdb_adapter;
  import riscv_pkg::*;

  logic         clk;
  logic         rst;
  fu_complete_t fc;
  logic         gnt;
  logic         fl;
  logic         fen;
  rob_tag_t     ftag;
  rob_tag_t     htag;

  fu_complete_t req2, req3;
  logic         stall2, stall3;
  logic         ovf2, ovf3;

  int checks   = 0;
  int failures = 0;

  fu_cdb_adapter #(.DEPTH(2)) u_d2 (
    .i_clk(clk), .i_rst(rst), .i_fu_complete(fc), .o_cdb_req(req2),
    .i_cdb_grant(gnt), .o_fu_stall(stall2), .o_overflow(ovf2),
    .i_flush(fl), .i_flush_en(fen), .i_flush_tag(ftag), .i_rob_head_tag(htag)
  );

  fu_cdb_adapter #(.DEPTH(3)) u_d3 (
    .i_clk(clk), .i_rst(rst), .i_fu_complete(fc), .o_cdb_req(req3),
    .i_cdb_grant(gnt), .o_fu_stall(stall3), .o_overflow(ovf3),
    .i_flush(fl), .i_flush_en(fen), .i_flush_tag(ftag), .i_rob_head_tag(htag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic     rst, v;
    rob_tag_t tag;
    logic     gnt, fl, fen;
    rob_tag_t ftag, head;
    logic     ev;
    rob_tag_t etag;
    logic     est, eov;
  } vec_t;

  typedef struct {
    fu_complete_t c;
    bit           killed;
  } mentry_t;

  vec_t    tv[$];
  mentry_t mq[2][$];
  bit      movf[2];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic fu_complete_t mk(input rob_tag_t t);
    fu_complete_t r;
    r.valid     = 1'b1;
    r.tag       = t;
    r.value     = (t == 4'd5) ? 64'hFFFF_FFFF_3F80_0000 : {32'hA5A5_0000, 28'h0, t};
    r.exception = t[0];
    r.exc_cause = exc_cause_t'({2'b00, t[2:0]});
    r.fp_flags  = fp_flags_t'({t, t[3]});
    return r;
  endfunction

  task automatic add_vec(input logic r, input logic v, input int t, input logic g,
                         input logic f, input logic fe, input int ft, input int h,
                         input logic ev, input int et, input logic est, input logic eov);
    vec_t x;
    x.rst = r; x.v = v; x.tag = rob_tag_t'(t); x.gnt = g; x.fl = f; x.fen = fe;
    x.ftag = rob_tag_t'(ft); x.head = rob_tag_t'(h);
    x.ev = ev; x.etag = rob_tag_t'(et); x.est = est; x.eov = eov;
    tv.push_back(x);
  endtask

  task automatic drive_idle();
    rst = 1'b0; fc = '0; gnt = 1'b0; fl = 1'b0; fen = 1'b0; ftag = '0; htag = '0;
  endtask

  function automatic bit m_younger(input int t, input int ft, input int h);
    int m;
    m = 1 << (ReorderBufferTagWidth + 1);
    return (((t - h) % m + m) % m) > (((ft - h) % m + m) % m);
  endfunction

  task automatic model_step(input int k, input int depth);
    bit head_ok, pop, young_in, want;
    if (rst) begin
      mq[k].delete();
      movf[k] = 1'b0;
      return;
    end
    if (fl) begin
      mq[k].delete();
      return;
    end
    head_ok  = (mq[k].size() > 0) && !mq[k][0].killed;
    pop      = (mq[k].size() > 0) && (mq[k][0].killed || (gnt && head_ok));
    young_in = fen && m_younger(int'(fc.tag), int'(ftag), int'(htag));
    want     = fc.valid && !young_in;
    if (fen) begin
      for (int j = 0; j < mq[k].size(); j++) begin
        if (m_younger(int'(mq[k][j].c.tag), int'(ftag), int'(htag)))
          mq[k][j].killed = 1'b1;
      end
    end
    if (pop) void'(mq[k].pop_front());
    if (want) begin
      if (mq[k].size() < depth) mq[k].push_back('{c: fc, killed: 1'b0});
      else movf[k] = 1'b1;
    end
  endtask

  function automatic fu_complete_t m_req(input int k);
    fu_complete_t r;
    r = '0;
    if (mq[k].size() > 0 && !mq[k][0].killed) r = mq[k][0].c;
    return r;
  endfunction

  initial begin
    fu_complete_t exp_req;
    string nm;

    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_req_d2",   96'(req2),   96'(0));
    chk("reset_stall_d2", 96'(stall2), 96'(0));
    chk("reset_ovf_d2",   96'(ovf2),   96'(0));
    chk("reset_req_d3",   96'(req3),   96'(0));

    // rst v tag g fl fen ftag head | ev etag est eov
    add_vec(0,1, 5,1,0,0,0,0, 1, 5,1,0);
    add_vec(0,0, 0,1,0,0,0,0, 0, 0,0,0);
    add_vec(0,1, 3,0,0,0,0,0, 1, 3,1,0);
    add_vec(0,1, 4,0,0,0,0,0, 1, 3,1,0);
    add_vec(0,1, 6,0,0,0,0,0, 1, 3,1,1);
    add_vec(0,0, 0,0,0,0,0,0, 1, 3,1,1);
    add_vec(0,0, 0,1,0,0,0,0, 1, 4,1,1);
    add_vec(0,0, 0,1,0,0,0,0, 0, 0,0,1);
    add_vec(1,0, 0,0,0,0,0,0, 0, 0,0,0);
    add_vec(0,1, 3,0,0,0,0,0, 1, 3,1,0);
    add_vec(0,1, 4,0,0,0,0,0, 1, 3,1,0);
    add_vec(0,1, 7,1,0,0,0,0, 1, 4,1,0);
    add_vec(0,0, 0,1,0,0,0,0, 1, 7,1,0);
    add_vec(0,0, 0,1,0,0,0,0, 0, 0,0,0);
    add_vec(0,0, 0,1,0,0,0,0, 0, 0,0,0);
    add_vec(0,1, 8,0,0,0,0,0, 1, 8,1,0);
    add_vec(0,1, 9,1,1,0,0,0, 0, 0,0,0);
    add_vec(0,0, 0,0,0,0,0,0, 0, 0,0,0);
    add_vec(0,1, 1,0,0,0,0,0, 1, 1,1,0);
    add_vec(0,1, 2,0,0,0,0,0, 1, 1,1,0);
    add_vec(1,1, 3,1,0,0,0,0, 0, 0,0,0);
    add_vec(0,0, 0,0,0,0,0,0, 0, 0,0,0);
    add_vec(0,1, 3,0,0,0,0,0, 1, 3,1,0);
    add_vec(0,1, 6,0,0,0,0,0, 1, 3,1,0);
    add_vec(0,0, 0,0,0,1,4,2, 1, 3,1,0);
    add_vec(0,0, 0,1,0,0,0,0, 0, 0,1,0);
    add_vec(0,0, 0,0,0,0,0,0, 0, 0,0,0);
    add_vec(0,1,15,0,0,0,0,0, 1,15,1,0);
    add_vec(0,1, 1,0,0,0,0,0, 1,15,1,0);
    add_vec(0,0, 0,0,0,1,0,14,1,15,1,0);
    add_vec(0,0, 0,1,0,0,0,0, 0, 0,1,0);
    add_vec(0,0, 0,0,0,0,0,0, 0, 0,0,0);
    add_vec(0,1, 9,0,0,1,4,2, 0, 0,0,0);
    add_vec(0,1, 4,0,0,1,4,2, 1, 4,1,0);
    add_vec(0,0, 0,1,0,0,0,0, 0, 0,0,0);

    for (int i = 0; i < tv.size(); i++) begin
      rst  = tv[i].rst;
      fc   = mk(tv[i].tag);
      fc.valid = tv[i].v;
      gnt  = tv[i].gnt;
      fl   = tv[i].fl;
      fen  = tv[i].fen;
      ftag = tv[i].ftag;
      htag = tv[i].head;
      @(posedge clk); #1;
      exp_req = tv[i].ev ? mk(tv[i].etag) : '0;
      nm = $sformatf("vec%0d_req", i);
      chk(nm, 96'(req2), 96'(exp_req));
      nm = $sformatf("vec%0d_stall", i);
      chk(nm, 96'(stall2), 96'(tv[i].est));
      nm = $sformatf("vec%0d_ovf", i);
      chk(nm, 96'(ovf2), 96'(tv[i].eov));
    end

    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    fc = mk(4'd10);
    #2;
    chk("no_bypass", 96'(req2.valid), 96'(0));
    @(posedge clk); #1;
    chk("first_visible", 96'(req2), 96'(mk(4'd10)));
    drive_idle();
    rst = 1'b1;
    gnt = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_req",   96'(req2),   96'(0));
    chk("mid_reset_stall", 96'(stall2), 96'(0));
    drive_idle();
    @(posedge clk); #1;
    chk("post_reset_req", 96'(req2), 96'(0));

    for (int c = 0; c < 3000; c++) begin
      rst  = (c == 0) || ($urandom_range(99) == 0);
      fl   = ($urandom_range(49) == 0);
      fen  = ($urandom_range(7) == 0);
      gnt  = $urandom_range(1);
      ftag = rob_tag_t'($urandom_range(15));
      htag = rob_tag_t'($urandom_range(15));
      fc.valid     = ($urandom_range(9) < 7);
      fc.tag       = rob_tag_t'($urandom_range(15));
      fc.value     = {$urandom, $urandom};
      fc.exception = $urandom_range(1);
      fc.exc_cause = exc_cause_t'($urandom_range(7));
      fc.fp_flags  = fp_flags_t'($urandom_range(31));
      model_step(0, 2);
      model_step(1, 3);
      @(posedge clk); #1;
      chk("rnd_d2_req",   96'(req2),   96'(m_req(0)));
      chk("rnd_d2_stall", 96'(stall2), 96'(mq[0].size() >= 1));
      chk("rnd_d2_ovf",   96'(ovf2),   96'(movf[0]));
      chk("rnd_d3_req",   96'(req3),   96'(m_req(1)));
      chk("rnd_d3_stall", 96'(stall3), 96'(mq[1].size() >= 2));
      chk("rnd_d3_ovf",   96'(ovf3),   96'(movf[1]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
